// File: rtl/mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer
//
// Steps a downstream 4:1 mux through the enabled channels of a mask, waits a
// programmable number of settle cycles after each select change, captures the
// mux output and offers it to a consumer with a valid/ready handshake.
//
// Ports
//   clk       : single clock, rising-edge active
//   rst_n     : asynchronous active-low reset
//   start     : single-cycle pulse, begins a scan from the lowest enabled channel
//   stop      : single-cycle pulse, ends the scan after the current capture
//   mask[3:0] : per-channel enable (bit i enables channel i)
//   dwell[3:0]: settle cycles before capture (0..15)
//   mux_y[3:0]: data returned by the downstream mux for the current sel
//   sel[1:0]  : select code driven to the mux
//   data_out  : captured channel data
//   chan_out  : channel index of data_out
//   valid     : data_out/chan_out valid
//   ready     : consumer accepts when valid && ready
//   busy      : high whenever a scan is in progress (SETTLE or HOLD)
// -----------------------------------------------------------------------------
module mux_scan_sequencer #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [3:0]        mask,
  input  logic [3:0]        dwell,
  input  logic [DATA_W-1:0] mux_y,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        chan_out,
  output logic              valid,
  input  logic              ready,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SETTLE = 2'b01;
  localparam logic [1:0] HOLD   = 2'b10;

  logic [1:0] state;
  logic [3:0] cnt;
  logic       stop_pend;

  // First enabled channel found searching upward from 'from', wrapping 3->0.
  // Searching from cur+1 gives "next above current"; with a single enabled
  // channel the search wraps back onto that same channel.
  function automatic logic [1:0] first_enabled(input logic [3:0] m,
                                               input logic [1:0] from);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = from;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = from + 2'(i);
      if (!found && m[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 2'b00;
      data_out  <= '0;
      chan_out  <= 2'b00;
      valid     <= 1'b0;
      cnt       <= 4'd0;
      stop_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A start colliding with stop, or with nothing enabled, is dropped.
          if (start && !stop && (mask != 4'b0000)) begin
            sel   <= first_enabled(mask, 2'd0);
            cnt   <= dwell;
            state <= SETTLE;
          end
        end

        // Settle: count down dwell, then capture on the zero cycle
        SETTLE: begin
          if (stop) stop_pend <= 1'b1;
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            data_out <= mux_y;
            chan_out <= sel;
            valid    <= 1'b1;
            state    <= HOLD;
          end
        end

        // Hold: outputs frozen until the consumer takes the sample
        HOLD: begin
          if (valid && ready) begin
            valid <= 1'b0;
            // A stop arriving on the handshake cycle itself counts as pending.
            // mask and dwell are sampled here, at the advance, and nowhere else
            // during a scan.
            if (stop_pend || stop || (mask == 4'b0000)) begin
              state     <= IDLE;
              stop_pend <= 1'b0;
            end else begin
              sel   <= first_enabled(mask, sel + 2'd1);
              cnt   <= dwell;
              state <= SETTLE;
            end
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
module tb_mux_scan_sequencer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic [3:0] mask  = 4'b0000;
  logic [3:0] dwell = 4'd0;
  logic       ready = 1'b0;
  logic [3:0] mux_y;
  logic [1:0] sel;
  logic [3:0] data_out;
  logic [1:0] chan_out;
  logic       valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] chan;
    logic [3:0] data;
  } cap_t;

  cap_t exp_q[$];

  mux_scan_sequencer #(.DATA_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .mask     (mask),
    .dwell    (dwell),
    .mux_y    (mux_y),
    .sel      (sel),
    .data_out (data_out),
    .chan_out (chan_out),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Downstream 4:1 mux model: A=1010, B=1011, C=1100, D=1101
  always_comb begin
    case (sel)
      2'd0:    mux_y = 4'b1010;
      2'd1:    mux_y = 4'b1011;
      2'd2:    mux_y = 4'b1100;
      default: mux_y = 4'b1101;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (sel !== 2'b00 || data_out !== 4'b0000 || chan_out !== 2'b00 ||
        valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state sel=%b data=%b chan=%b valid=%b busy=%b, required 00 0000 00 0 0",
               sel, data_out, chan_out, valid, busy);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b valid=%b, required 0 0", busy, valid);
    end
  endtask

  task automatic test_full_scan();
    int   settle;
    bit   done;
    cap_t e;
    mask  = 4'b1111;
    dwell = 4'd0;
    ready = 1'b1;
    exp_q.push_back('{2'd0, 4'b1010});
    exp_q.push_back('{2'd1, 4'b1011});
    exp_q.push_back('{2'd2, 4'b1100});
    exp_q.push_back('{2'd3, 4'b1101});
    exp_q.push_back('{2'd0, 4'b1010});
    start = 1'b1;
    step();
    start = 1'b0;
    settle = 0;
    done   = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (valid) begin
        checks++;
        if (settle != 1) begin
          failures++;
          $display("FAIL full_latency settle=%0d, required 1", settle);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL full_extra chan=%0d data=%b, required no capture", chan_out, data_out);
        end else begin
          e = exp_q.pop_front();
          if (chan_out !== e.chan || data_out !== e.data) begin
            failures++;
            $display("FAIL full_capture chan=%0d data=%b, required chan=%0d data=%b",
                     chan_out, data_out, e.chan, e.data);
          end
        end
        settle = 0;
        if (exp_q.size() == 0) begin
          stop = 1'b1;           // coincident with the handshake
          step();
          stop = 1'b0;
          done = 1'b1;
        end else begin
          step();
        end
      end else begin
        if (busy) settle++;
        step();
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL full_timeout remaining=%0d, required 0", exp_q.size());
    end
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || sel !== 2'd0) begin
      failures++;
      $display("FAIL full_stop_end busy=%b valid=%b sel=%0d, required 0 0 0", busy, valid, sel);
    end
    exp_q.delete();
  endtask

  task automatic test_sparse_wrap();
    int   settle;
    bit   done;
    cap_t e;
    mask  = 4'b1010;
    dwell = 4'd2;
    ready = 1'b1;
    exp_q.push_back('{2'd1, 4'b1011});
    exp_q.push_back('{2'd3, 4'b1101});
    exp_q.push_back('{2'd1, 4'b1011});
    exp_q.push_back('{2'd3, 4'b1101});
    start = 1'b1;
    step();
    start = 1'b0;
    settle = 0;
    done   = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (valid) begin
        checks++;
        if (settle != 3) begin
          failures++;
          $display("FAIL sparse_latency settle=%0d, required 3", settle);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sparse_extra chan=%0d data=%b, required no capture", chan_out, data_out);
        end else begin
          e = exp_q.pop_front();
          if (chan_out !== e.chan || data_out !== e.data || sel !== e.chan) begin
            failures++;
            $display("FAIL sparse_capture chan=%0d data=%b sel=%0d, required chan=%0d data=%b sel=%0d",
                     chan_out, data_out, sel, e.chan, e.data, e.chan);
          end
        end
        settle = 0;
        if (exp_q.size() == 0) begin
          stop = 1'b1;
          step();
          stop = 1'b0;
          done = 1'b1;
        end else begin
          step();
        end
      end else begin
        if (busy) settle++;
        step();
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL sparse_timeout remaining=%0d, required 0", exp_q.size());
    end
    checks++;
    if (busy !== 1'b0 || sel !== 2'd3) begin
      failures++;
      $display("FAIL sparse_end busy=%b sel=%0d, required 0 3", busy, sel);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int   settle;
    int   wait_cyc;
    cap_t e;
    mask  = 4'b1111;
    dwell = 4'd1;
    ready = 1'b0;
    exp_q.push_back('{2'd0, 4'b1010});
    exp_q.push_back('{2'd1, 4'b1011});
    start = 1'b1;
    step();
    start = 1'b0;
    wait_cyc = 0;
    while (!valid && wait_cyc < 20) begin
      step();
      wait_cyc++;
    end
    checks++;
    if (!valid) begin
      failures++;
      $display("FAIL bp_first_timeout valid=%b, required 1", valid);
    end
    e = exp_q.pop_front();
    checks++;
    if (chan_out !== e.chan || data_out !== e.data) begin
      failures++;
      $display("FAIL bp_first_capture chan=%0d data=%b, required chan=%0d data=%b",
               chan_out, data_out, e.chan, e.data);
    end
    // mask is disturbed while held; it must only matter at the advance
    mask = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (valid !== 1'b1 || data_out !== e.data || chan_out !== e.chan || sel !== e.chan) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d valid=%b data=%b chan=%0d sel=%0d, required 1 %b %0d %0d",
                 i, valid, data_out, chan_out, sel, e.data, e.chan, e.chan);
      end
    end
    mask  = 4'b1111;
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1 || sel !== 2'd1) begin
      failures++;
      $display("FAIL bp_handshake valid=%b busy=%b sel=%0d, required 0 1 1", valid, busy, sel);
    end
    settle = 0;
    wait_cyc = 0;
    while (!valid && wait_cyc < 20) begin
      if (busy) settle++;
      step();
      wait_cyc++;
    end
    checks++;
    if (settle != 2) begin
      failures++;
      $display("FAIL bp_latency settle=%0d, required 2", settle);
    end
    e = exp_q.pop_front();
    checks++;
    if (valid !== 1'b1 || chan_out !== e.chan || data_out !== e.data) begin
      failures++;
      $display("FAIL bp_second_capture valid=%b chan=%0d data=%b, required 1 %0d %b",
               valid, chan_out, data_out, e.chan, e.data);
    end
    // stop during HOLD is only pending until the handshake
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_stop_hold valid=%b busy=%b, required 1 1", valid, busy);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || sel !== 2'd1) begin
      failures++;
      $display("FAIL bp_stop_end valid=%b busy=%b sel=%0d, required 0 0 1", valid, busy, sel);
    end
    exp_q.delete();
  endtask

  task automatic test_stop();
    int   settle;
    bit   done;
    bit   stopped;
    cap_t e;
    mask  = 4'b1111;
    dwell = 4'd3;
    ready = 1'b1;
    exp_q.push_back('{2'd0, 4'b1010});
    exp_q.push_back('{2'd1, 4'b1011});
    exp_q.push_back('{2'd2, 4'b1100});
    start = 1'b1;
    step();
    start = 1'b0;
    settle  = 0;
    done    = 1'b0;
    stopped = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (valid) begin
        checks++;
        if (settle != 4) begin
          failures++;
          $display("FAIL stop_latency settle=%0d, required 4", settle);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stop_extra chan=%0d data=%b, required no capture", chan_out, data_out);
        end else begin
          e = exp_q.pop_front();
          if (chan_out !== e.chan || data_out !== e.data) begin
            failures++;
            $display("FAIL stop_capture chan=%0d data=%b, required chan=%0d data=%b",
                     chan_out, data_out, e.chan, e.data);
          end
        end
        settle = 0;
        if (exp_q.size() == 0) done = 1'b1;
        step();
      end else begin
        if (busy) settle++;
        if (busy && sel == 2'd2 && !stopped) begin
          stop    = 1'b1;
          stopped = 1'b1;
        end
        step();
        stop = 1'b0;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL stop_timeout remaining=%0d, required 0", exp_q.size());
    end
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || sel !== 2'd2) begin
      failures++;
      $display("FAIL stop_idle busy=%b valid=%b sel=%0d, required 0 0 2", busy, valid, sel);
    end
    step();
    step();
    step();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || sel !== 2'd2) begin
      failures++;
      $display("FAIL stop_stays_idle busy=%b valid=%b sel=%0d, required 0 0 2", busy, valid, sel);
    end
    exp_q.delete();
  endtask

  task automatic test_illegal_start();
    int   wait_cyc;
    cap_t e;
    ready = 1'b0;
    mask  = 4'b0000;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || sel !== 2'd2) begin
      failures++;
      $display("FAIL illegal_mask0 busy=%b sel=%0d, required 0 2", busy, sel);
    end
    mask  = 4'b1111;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || sel !== 2'd2) begin
      failures++;
      $display("FAIL illegal_start_stop busy=%b valid=%b sel=%0d, required 0 0 2", busy, valid, sel);
    end
    // stop in IDLE alone must leave nothing pending for the next scan
    stop = 1'b1;
    step();
    stop = 1'b0;
    dwell = 4'd0;
    exp_q.push_back('{2'd0, 4'b1010});
    exp_q.push_back('{2'd1, 4'b1011});
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || sel !== 2'd0) begin
      failures++;
      $display("FAIL legal_start busy=%b sel=%0d, required 1 0", busy, sel);
    end
    ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      wait_cyc = 0;
      while (!valid && wait_cyc < 20) begin
        step();
        wait_cyc++;
      end
      e = exp_q.pop_front();
      checks++;
      if (valid !== 1'b1 || chan_out !== e.chan || data_out !== e.data) begin
        failures++;
        $display("FAIL idle_stop_ignored valid=%b chan=%0d data=%b, required 1 %0d %b",
                 valid, chan_out, data_out, e.chan, e.data);
      end
      if (n == 1) stop = 1'b1;
      step();
      stop = 1'b0;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL illegal_end busy=%b, required 0", busy);
    end
    ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int   wait_cyc;
    cap_t e;
    mask  = 4'b0100;
    dwell = 4'd0;
    ready = 1'b0;
    exp_q.push_back('{2'd2, 4'b1100});
    start = 1'b1;
    step();
    start = 1'b0;
    wait_cyc = 0;
    while (!valid && wait_cyc < 20) begin
      step();
      wait_cyc++;
    end
    e = exp_q.pop_front();
    checks++;
    if (valid !== 1'b1 || chan_out !== e.chan || data_out !== e.data || sel !== e.chan) begin
      failures++;
      $display("FAIL rst_mid_capture valid=%b chan=%0d data=%b sel=%0d, required 1 %0d %b %0d",
               valid, chan_out, data_out, sel, e.chan, e.data, e.chan);
    end
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || sel !== 2'b00 || data_out !== 4'b0000 ||
        chan_out !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_async valid=%b sel=%b data=%b chan=%b busy=%b, required 0 00 0000 00 0",
               valid, sel, data_out, chan_out, busy);
    end
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    step();
    step();
    step();
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || sel !== 2'b00) begin
      failures++;
      $display("FAIL rst_abandon valid=%b busy=%b sel=%0d, required 0 0 0", valid, busy, sel);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_sparse_wrap();
    test_backpressure();
    test_stop();
    test_illegal_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
